// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: deserialises 11-bit frames into scan codes and keeps a 3-byte history.
// Optional PS2_GLITCH_FILTER_EN adds a FILTER_LEN-cycle level filter on the PS/2 clock.
module ps2_scan_receiver #(
  parameter int TIMEOUT_CYCLES = 25000
`ifdef PS2_GLITCH_FILTER_EN
  , parameter int FILTER_LEN = 8
`endif
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_ps2_clk,
  input  logic        i_ps2_data,
  output logic [23:0] o_KeyData,
  output logic        o_Valid,
  output logic        o_Error,
  output logic        o_Busy
);

  localparam int TCW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]     clkSync_q;
  logic [1:0]     dataSync_q;
  logic           clkLevel_d;
  logic           clkPrev_q;
  logic           fallEdge_d;
  logic           dataBit_d;
  state_t         state_q;
  logic [2:0]     bitCnt_q;
  logic [7:0]     shift_q;
  logic           parity_q;
  logic [TCW-1:0] tmoCnt_q;
  logic [23:0]    keyData_q;
  logic           valid_q;
  logic           error_q;

  // Both pins are asynchronous; idle-high reset value avoids a false edge after reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      clkSync_q  <= 2'b11;
      dataSync_q <= 2'b11;
    end else begin
      clkSync_q  <= {clkSync_q[0], i_ps2_clk};
      dataSync_q <= {dataSync_q[0], i_ps2_data};
    end
  end

`ifdef PS2_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);
  logic           filtLevel_q;
  logic [FCW-1:0] filtCnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      filtLevel_q <= 1'b1;
      filtCnt_q   <= '0;
    end else if (clkSync_q[1] == filtLevel_q) begin
      filtCnt_q <= '0;
    end else if (filtCnt_q == FCW'(FILTER_LEN - 1)) begin
      filtLevel_q <= clkSync_q[1];
      filtCnt_q   <= '0;
    end else begin
      filtCnt_q <= filtCnt_q + 1'b1;
    end
  end

  assign clkLevel_d = filtLevel_q;
`else
  assign clkLevel_d = clkSync_q[1];
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) clkPrev_q <= 1'b1;
    else          clkPrev_q <= clkLevel_d;
  end

  assign fallEdge_d = clkPrev_q & ~clkLevel_d;
  assign dataBit_d  = dataSync_q[1];

  // Frame FSM: one step per accepted falling edge; the timeout counter only advances
  // mid-frame and aborts at its last value, so it never wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tmoCnt_q  <= '0;
      keyData_q <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (fallEdge_d) begin
        tmoCnt_q <= '0;
        case (state_q)
          IDLE: begin
            if (!dataBit_d) begin
              state_q  <= DATA;
              bitCnt_q <= '0;
            end
          end
          DATA: begin
            shift_q  <= {dataBit_d, shift_q[7:1]};
            bitCnt_q <= bitCnt_q + 1'b1;
            if (bitCnt_q == 3'd7) state_q <= PARITY;
          end
          PARITY: begin
            parity_q <= dataBit_d;
            state_q  <= STOP;
          end
          STOP: begin
            if (dataBit_d && (^{shift_q, parity_q})) begin
              keyData_q <= {keyData_q[15:0], shift_q};
              valid_q   <= 1'b1;
            end else begin
              error_q <= 1'b1;
            end
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end else if (state_q != IDLE) begin
        if (tmoCnt_q == TIMEOUT_LAST) begin
          state_q  <= IDLE;
          error_q  <= 1'b1;
          tmoCnt_q <= '0;
        end else begin
          tmoCnt_q <= tmoCnt_q + 1'b1;
        end
      end
    end
  end

  assign o_KeyData = keyData_q;
  assign o_Valid   = valid_q;
  assign o_Error   = error_q;
  assign o_Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Scoreboard bench for ps2_scan_receiver: directed and random PS/2 frames checked
// against a byte-history model; glitch test only when PS2_GLITCH_FILTER_EN is defined.
module tb_ps2_scan_receiver;

  localparam int TIMEOUT = 25000;
  localparam int HALF    = 20;

  logic        clk     = 1'b0;
  logic        rstN    = 1'b0;
  logic        ps2Clk  = 1'b1;
  logic        ps2Data = 1'b1;
  logic [23:0] keyData;
  logic        valid;
  logic        error;
  logic        busy;

  typedef struct {
    bit          isErr;
    logic [23:0] key;
  } exp_t;

  exp_t        expQ[$];
  logic [7:0]  history[$];
  int          testsRun    = 0;
  int          testsFailed = 0;
  bit          monEn       = 1'b0;

  ps2_scan_receiver #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_ps2_clk  (ps2Clk),
    .i_ps2_data (ps2Data),
    .o_KeyData  (keyData),
    .o_Valid    (valid),
    .o_Error    (error),
    .o_Busy     (busy)
  );

  always #5 clk = ~clk;

  // Model: history of good bytes, newest first; the display word is the last three.
  function automatic logic [23:0] modelKey();
    logic [23:0] k;
    k = '0;
    for (int i = 0; i < 3; i++)
      if (i < history.size()) k[i*8 +: 8] = history[i];
    return k;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    testsRun++;
    if (act !== req) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor pops one expectation per valid/error pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (monEn && (valid || error)) begin
      exp_t e;
      checkOutput("valid_error_exclusive", {31'd0, valid & error}, 32'd0);
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected_event: valid=%0b error=%0b key=%06h", valid, error, keyData);
      end else begin
        e = expQ.pop_front();
        checkOutput("event_is_error", {31'd0, error}, {31'd0, e.isErr});
        checkOutput("key_data", {8'd0, keyData}, {8'd0, e.key});
      end
    end
  end

  task automatic ps2Bit(input logic b);
    @(negedge clk) ps2Data = b;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2Clk = 1'b1;
  endtask

  // Sends one frame; the expected response is queued before the first bit goes out.
  task automatic applyStimulus(input logic [7:0] d, input bit flipPar, input bit badStop);
    logic par;
    exp_t e;
    par = (~^d) ^ flipPar;
    if (!flipPar && !badStop) begin
      history.push_front(d);
      if (history.size() > 3) void'(history.pop_back());
      e.isErr = 1'b0;
    end else begin
      e.isErr = 1'b1;
    end
    e.key = modelKey();
    expQ.push_back(e);
    ps2Bit(1'b0);
    for (int i = 0; i < 8; i++) ps2Bit(d[i]);
    ps2Bit(par);
    ps2Bit(!badStop);
    @(negedge clk) ps2Data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    checkOutput("reset_key", {8'd0, keyData}, 32'd0);
    checkOutput("reset_valid", {31'd0, valid}, 32'd0);
    checkOutput("reset_error", {31'd0, error}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rstN  = 1'b1;
    monEn = 1'b1;
    repeat (5) @(negedge clk);

    applyStimulus(8'h1C, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b0, 1'b0);
    applyStimulus(8'h1C, 1'b1, 1'b0);
    applyStimulus(8'h44, 1'b0, 1'b1);
    applyStimulus(8'hF0, 1'b0, 1'b0);
    applyStimulus(8'hF0, 1'b0, 1'b0);

    // Partial frame left hanging until the timeout aborts it.
    ps2Bit(1'b0);
    for (int i = 0; i < 4; i++) ps2Bit(1'($urandom_range(0, 1)));
    @(negedge clk);
    checkOutput("busy_mid_frame", {31'd0, busy}, 32'd1);
    e.isErr = 1'b1;
    e.key   = modelKey();
    expQ.push_back(e);
    repeat (TIMEOUT + 10) @(negedge clk);
    checkOutput("busy_after_timeout", {31'd0, busy}, 32'd0);
    checkOutput("timeout_reported", expQ.size(), 32'd0);
    applyStimulus(8'h5A, 1'b0, 1'b0);

    // Reset in the middle of a frame drops the partial byte and the history.
    ps2Bit(1'b0);
    for (int i = 0; i < 3; i++) ps2Bit(1'($urandom_range(0, 1)));
    @(negedge clk) rstN = 1'b0;
    @(negedge clk) rstN = 1'b1;
    history.delete();
    checkOutput("midframe_reset_key", {8'd0, keyData}, 32'd0);
    checkOutput("midframe_reset_busy", {31'd0, busy}, 32'd0);
    ps2Data = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(8'h29, 1'b0, 1'b0);

`ifdef PS2_GLITCH_FILTER_EN
    @(negedge clk) ps2Data = 1'b0;
    repeat (4) @(negedge clk);
    ps2Clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2Clk = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("glitch_ignored_busy", {31'd0, busy}, 32'd0);
    ps2Data = 1'b1;
    applyStimulus(8'h66, 1'b0, 1'b0);
`endif

    for (int n = 0; n < 30; n++) begin
      int r;
      r = $urandom_range(0, 9);
      applyStimulus(8'($urandom_range(0, 255)), r == 0, r == 1);
    end

    for (int c = 0; c < 200 && expQ.size() != 0; c++) @(negedge clk);
    checkOutput("queue_drained", expQ.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
